// File: rtl/dtc_pkg.sv
// rtl/dtc_pkg.sv - shared types, widths and FSM states for the decision-tree classifier
package dtc_pkg;
  localparam int DEF_N_FEAT    = 8;
  localparam int DEF_CLS_W     = 2;
  localparam int DEF_N_NODES   = 32;
  localparam int DEF_MAX_DEPTH = 16;

  function automatic int fw_of(input int n_feat);
    return (n_feat > 1) ? $clog2(n_feat) : 1;
  endfunction

  function automatic int aw_of(input int n_nodes);
    return (n_nodes > 1) ? $clog2(n_nodes) : 1;
  endfunction

  function automatic int node_w_of(input int n_feat, input int n_nodes);
    return 1 + fw_of(n_feat) + 2 * aw_of(n_nodes);
  endfunction

  localparam int DEF_FW     = fw_of(DEF_N_FEAT);
  localparam int DEF_AW     = aw_of(DEF_N_NODES);
  localparam int DEF_NODE_W = node_w_of(DEF_N_FEAT, DEF_N_NODES);

  // Field order matches the packed cfg_node word {leaf, feat, lo, hi}
  typedef struct packed {
    logic              leaf;
    logic [DEF_FW-1:0] feat;
    logic [DEF_AW-1:0] lo;
    logic [DEF_AW-1:0] hi;
  } dtc_node_t;

  typedef enum logic [1:0] {IDLE, WALK, DONE} dtc_state_t;
endpackage

// File: rtl/dtc_if.sv
// rtl/dtc_if.sv - config, sample and result handshake bundle for dtc_engine
interface dtc_if #(
  parameter int N_FEAT = 8,
  parameter int CLS_W  = 2,
  parameter int AW     = 5,
  parameter int NODE_W = 14
);
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [NODE_W-1:0] cfg_node;
  logic              cfg_ready;
  logic              in_valid;
  logic              in_ready;
  logic [N_FEAT-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CLS_W-1:0]  out_class;
  logic              out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_node, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_class, out_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_node, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_class, out_err
  );
endinterface

// File: rtl/dtc_node_table.sv
// rtl/dtc_node_table.sv - node register array, one sync write port, one comb read port
module dtc_node_table #(
  parameter int N_NODES = 32,
  parameter int AW      = 5,
  parameter int NODE_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [NODE_W-1:0] rdata
);
  // Leaf flag set, class 0: an unprogrammed table classifies everything as 0
  localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W-1){1'b0}}};

  logic [NODE_W-1:0] mem [N_NODES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) mem[i] <= LEAF0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dtc_engine.sv
// rtl/dtc_engine.sv - programmable decision-tree classifier, one node per cycle
module dtc_engine
  import dtc_pkg::*;
#(
  parameter int N_FEAT    = DEF_N_FEAT,
  parameter int CLS_W     = DEF_CLS_W,
  parameter int N_NODES   = DEF_N_NODES,
  parameter int MAX_DEPTH = DEF_MAX_DEPTH
) (
  input logic  clk,
  input logic  rst,
  dtc_if.slave bus
);
  localparam int FW     = fw_of(N_FEAT);
  localparam int AW     = aw_of(N_NODES);
  localparam int NODE_W = node_w_of(N_FEAT, N_NODES);
  localparam int DW     = $clog2(MAX_DEPTH + 1);

  dtc_state_t        state, state_d;
  logic [N_FEAT-1:0] sample, sample_d;
  logic [AW-1:0]     ptr, ptr_d;
  logic [DW-1:0]     depth, depth_d, depth_inc;
  logic [CLS_W-1:0]  cls_q, cls_d;
  logic              err_q, err_d;

  logic [NODE_W-1:0] node_word;
  logic              n_leaf, fbit, child_oob;
  logic [FW-1:0]     n_feat;
  logic [AW-1:0]     n_lo, n_hi, child;

  dtc_node_table #(.N_NODES(N_NODES), .AW(AW), .NODE_W(NODE_W)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.cfg_we && (state == IDLE)),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_node),
    .raddr (ptr),
    .rdata (node_word)
  );

  assign n_leaf    = node_word[NODE_W-1];
  assign n_feat    = node_word[NODE_W-2 -: FW];
  assign n_lo      = node_word[2*AW-1 -: AW];
  assign n_hi      = node_word[AW-1:0];
  // Feature indices past the sample width read as 0
  assign fbit      = (32'(n_feat) < N_FEAT) ? sample[n_feat] : 1'b0;
  assign child     = fbit ? n_hi : n_lo;
  assign child_oob = (32'(child) >= N_NODES);
  assign depth_inc = depth + DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sample <= '0;
      ptr    <= '0;
      depth  <= '0;
      cls_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      sample <= sample_d;
      ptr    <= ptr_d;
      depth  <= depth_d;
      cls_q  <= cls_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    sample_d = sample;
    ptr_d    = ptr;
    depth_d  = depth;
    cls_d    = cls_q;
    err_d    = err_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sample_d = bus.in_data;
          ptr_d    = '0;
          depth_d  = '0;
          state_d  = WALK;
        end
      end
      WALK: begin
        if (n_leaf) begin
          cls_d   = n_hi[CLS_W-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (depth_inc == DW'(MAX_DEPTH) || child_oob) begin
          cls_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d   = child;
          depth_d = depth_inc;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.cfg_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_class = cls_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_dtc_engine.sv
// tb/tb_dtc_engine.sv - scoreboard-driven self-checking bench for dtc_engine
module tb_dtc_engine;
  import dtc_pkg::*;

  localparam int AW     = aw_of(DEF_N_NODES);
  localparam int NODE_W = node_w_of(DEF_N_FEAT, DEF_N_NODES);

  typedef struct packed {
    logic [1:0] cls;
    logic       err;
    logic [7:0] lat;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  res_t sb[$];

  dtc_if #(.N_FEAT(DEF_N_FEAT), .CLS_W(DEF_CLS_W), .AW(AW), .NODE_W(NODE_W)) bus ();

  dtc_engine #(
    .N_FEAT(DEF_N_FEAT), .CLS_W(DEF_CLS_W), .N_NODES(DEF_N_NODES), .MAX_DEPTH(DEF_MAX_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input res_t r);
    return $sformatf("cls=%0d err=%0d lat=%0d", r.cls, r.err, r.lat);
  endfunction

  function automatic dtc_node_t mk(input logic leaf, input int feat, input int lo, input int hi);
    dtc_node_t n;
    n.leaf = leaf;
    n.feat = DEF_FW'(feat);
    n.lo   = DEF_AW'(lo);
    n.hi   = DEF_AW'(hi);
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input dtc_node_t n);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(addr);
    bus.cfg_node = n;
    step();
    bus.cfg_we   = 1'b0;
  endtask

  // Presents one sample in IDLE; returns one cycle after acceptance (cycle 1)
  task automatic send(input logic [7:0] d, input res_t e);
    sb.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  // Waits for out_valid, timing from acceptance; lat 255 marks a timeout
  task automatic wait_out(input int start, output res_t r);
    int cyc = start;
    while (bus.out_valid !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    r.cls = bus.out_class;
    r.err = bus.out_err;
    r.lat = (bus.out_valid === 1'b1) ? 8'(cyc) : 8'hFF;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) step();
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    obs = {bus.in_ready, bus.cfg_ready, bus.out_valid, bus.out_err, bus.out_class};
    n_cmp++;
    if (obs !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 110000", obs);
    end
  endtask

  task automatic test_unprogrammed();
    res_t r, e;
    send(8'hA5, '{cls: 2'd0, err: 1'b0, lat: 8'd2});
    wait_out(1, r);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL unprogrammed: got %s want %s", fmt(r), fmt(e)); end
  endtask

  task automatic program_tree();
    cfg_write(0, mk(1'b0, 0, 1, 2));
    cfg_write(1, mk(1'b1, 0, 0, 3));
    cfg_write(2, mk(1'b1, 0, 0, 1));
  endtask

  task automatic test_tree();
    res_t r, e;
    logic [7:0] pats [3] = '{8'h01, 8'h00, 8'hFE};
    program_tree();
    foreach (pats[i]) begin
      send(pats[i], '{cls: pats[i][0] ? 2'd1 : 2'd3, err: 1'b0, lat: 8'd3});
      wait_out(1, r);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL tree_%h: got %s want %s", pats[i], fmt(r), fmt(e));
      end
    end
  endtask

  task automatic test_backpressure();
    res_t r, e;
    logic [4:0] obs;
    bus.out_ready = 1'b0;
    send(8'h01, '{cls: 2'd1, err: 1'b0, lat: 8'd3});
    wait_out(1, r);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL bp_result: got %s want %s", fmt(r), fmt(e)); end
    for (int k = 0; k < 5; k++) begin
      step();
      obs = {bus.out_valid, bus.out_class, bus.out_err, bus.in_ready};
      n_cmp++;
      if (obs !== 5'b10100) begin n_bad++; $display("FAIL bp_hold_%0d: got %b want 10100", k, obs); end
    end
    bus.out_ready = 1'b1;
    step();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_loop_err();
    res_t r, e;
    cfg_write(0, mk(1'b0, 0, 0, 0));
    send(8'h3C, '{cls: 2'd0, err: 1'b1, lat: 8'(DEF_MAX_DEPTH + 1)});
    wait_out(1, r);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL loop_err: got %s want %s", fmt(r), fmt(e)); end
  endtask

  task automatic test_cfg_gating();
    res_t r, e;
    program_tree();
    sb.push_back('{cls: 2'd1, err: 1'b0, lat: 8'd3});
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    step();
    bus.in_valid = 1'b0;
    cfg_write(2, mk(1'b1, 0, 0, 2));
    wait_out(2, r);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL cfg_in_walk: got %s want %s", fmt(r), fmt(e)); end
    send(8'h01, '{cls: 2'd1, err: 1'b0, lat: 8'd3});
    wait_out(1, r);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL cfg_ignored_rerun: got %s want %s", fmt(r), fmt(e)); end
    // Write and accept in the same IDLE cycle: the walk must see the new leaf
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(2);
    bus.cfg_node = mk(1'b1, 0, 0, 2);
    send(8'h01, '{cls: 2'd2, err: 1'b0, lat: 8'd3});
    wait_out(1, r);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL cfg_with_accept: got %s want %s", fmt(r), fmt(e)); end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom_range(0, 255));
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d: got %b want 1", k, bus.in_ready); end
      send(d, '{cls: d[0] ? 2'd2 : 2'd3, err: 1'b0, lat: 8'd3});
      wait_out(1, r);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e) begin n_bad++; $display("FAIL b2b_%0d_%h: got %s want %s", k, d, fmt(r), fmt(e)); end
    end
  endtask

  task automatic test_reset_midwalk();
    res_t r, e;
    logic [5:0] obs;
    bit seen = 1'b0;
    cfg_write(0, mk(1'b0, 0, 1, 1));
    cfg_write(1, mk(1'b0, 1, 3, 3));
    cfg_write(3, mk(1'b0, 2, 4, 4));
    cfg_write(4, mk(1'b1, 0, 0, 2));
    send(8'h00, '{cls: 2'd2, err: 1'b0, lat: 8'd5});
    wait_out(1, r);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL depth3: got %s want %s", fmt(r), fmt(e)); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs = {bus.in_ready, bus.cfg_ready, bus.out_valid, bus.out_err, bus.out_class};
    n_cmp++;
    if (obs !== 6'b110000) begin n_bad++; $display("FAIL midwalk_reset_state: got %b want 110000", obs); end
    repeat (20) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midwalk_dropped: got out_valid=1 want none"); end
    send(8'h00, '{cls: 2'd0, err: 1'b0, lat: 8'd2});
    wait_out(1, r);
    e = sb.pop_front();
    n_cmp++;
    if (r !== e) begin n_bad++; $display("FAIL midwalk_table_cleared: got %s want %s", fmt(r), fmt(e)); end
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_node  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_unprogrammed();
    test_tree();
    test_backpressure();
    test_loop_err();
    test_cfg_gating();
    test_back_to_back();
    test_reset_midwalk();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dtc_engine.md
# dtc_engine

Programmable decision-tree classifier: the generalised successor to our fixed, combinational per-model tree blocks. The tree is held in a writable node table rather than baked into logic, and samples are classified by an iterative walk of one node per cycle, with valid/ready handshakes on input and output. It sits between the feature-extraction stage and the class consumer. One engine serves any tree up to `N_NODES` nodes and `MAX_DEPTH` levels.

## Interface
- `N_FEAT`, 8: binary feature count (sample width).
- `CLS_W`, 2: class label width.
- `N_NODES`, 32: node-table entries; `AW = $clog2(N_NODES)`.
- `MAX_DEPTH`, 16: walk-step limit before error.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: node-table write strobe.
- `cfg_addr` in AW: node index to write.
- `cfg_node` in NODE_W: packed node word {leaf, feat[FW], lo[AW], hi[AW]}, where FW = $clog2(N_FEAT); in a leaf, the class is in `hi[CLS_W-1:0]`.
- `cfg_ready` out 1: writes accepted (high only in IDLE).
- `in_valid` in 1, `in_ready` out 1, `in_data` in N_FEAT: sample handshake.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_class` out CLS_W: result label.
- `out_err` out 1: walk aborted.

## Operation
- Internal node: the next index is `hi` if `sample[feat]` = 1, else `lo`. Root is index 0.
- FSM states:
  - IDLE: `in_ready`=1, `cfg_ready`=1. On `in_valid`: latch the sample, ptr=0, depth=0, go to WALK.
  - WALK: evaluate `node[ptr]`.
    - Leaf: latch class, err=0, go to DONE.
    - Otherwise: ptr=child, depth+1.
    - If depth+1 = MAX_DEPTH, or the child is ≥ N_NODES: class=0, err=1, go to DONE.
  - DONE: `out_valid`=1 and outputs held stable. On `out_ready`: go to IDLE.
- `feat` ≥ N_FEAT reads the feature bit as 0.
- `cfg_we` is honoured only when `cfg_ready`=1; otherwise it is ignored and the table is unchanged.
- If `cfg_we` and `in_valid` occur together in IDLE, both happen: the write lands first, so the walk sees the new node.
- Reset values:
  - All outputs 0 except `in_ready`=1 and `cfg_ready`=1.
  - State IDLE.
  - Every table entry is a leaf with class 0, so an unprogrammed engine returns class 0.
- Reset mid-walk drops the sample and restores the reset values; no `out_valid` is produced for the dropped sample.

## Timing
- Acceptance is cycle 0. A leaf at depth d (root = 0) is evaluated in WALK cycles 1..d+1. `out_valid` rises at cycle d+2.
- Table read is combinational from the register array; there is no read latency.
- Minimum turnaround per sample with `out_ready` held at 1: d+3 cycles. There is no overlap of samples.
- Error case: `out_valid` at cycle MAX_DEPTH+1.
- A write in cycle t is visible to a walk step in cycle t+1 onward.

## Structure
- Package `dtc_pkg` holds:
  - the `dtc_node_t` packed struct (leaf, feat, lo, hi);
  - width functions for FW, AW, NODE_W;
  - the FSM state enum {IDLE, WALK, DONE}.
- Sub-module `dtc_node_table`: register array with one synchronous write port, one combinational read port, and reset-to-leaf-0.
- The top level holds the FSM, the sample register, the ptr/depth counters and the output registers.

## Test plan
- Post-reset, no config: accept sample 8'hA5 → `out_class`=0, `out_err`=0, `out_valid` at cycle 2.
- Program node0 {feat0, lo=1, hi=2}, node1 leaf 3, node2 leaf 1. Sample 8'h01 → class 1 at cycle 3; sample 8'h00 → class 3 at cycle 3.
- Loop node0 {lo=0, hi=0}, MAX_DEPTH=16 → `out_err`=1, class 0, `out_valid` at cycle 17.
- Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0. Then assert `out_ready`: `in_ready`=1 the next cycle.
- `cfg_we` during WALK targeting node2 → ignored: a re-run of 8'h01 still yields class 1.
- Assert `rst` in WALK cycle 2 of a depth-3 walk → no `out_valid`, `in_ready`=1 next cycle, table back to all leaf-0.
